// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: 4-deep in-order instruction queue driving a registered ALU command port.
// Optional ALU_ISSUE_HAZARD_EN adds a 3-entry RAW scoreboard that stalls a dependent head.
module alu_issue_ctrl (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        ins_valid,
  output logic        ins_ready,
  input  logic [23:0] ins_data,
  output logic [3:0]  addr1,
  output logic [3:0]  addr2,
  output logic [3:0]  rd,
  output logic [2:0]  func,
  output logic [7:0]  memaddr,
  output logic        write,
  output logic        cmd_valid,
  output logic        busy,
  output logic        err_rsvd
);

  localparam logic [3:0] RSVD_REG    = 4'hF;
  localparam logic [2:0] BUBBLE_FUNC = 3'b010;

  logic [23:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count, count_nxt;
  logic        rdy_en;
  logic        push_acc, push_store, issue, hazard, sb_busy;
  logic [23:0] head;
  logic [3:0]  head_a1, head_a2;

  // Handshake: ins_data transfers on a rising clk1 edge where ins_valid && ins_ready;
  // the source holds ins_valid/ins_data until then. ins_ready stays low in reset and
  // rises on the first edge after release.
  assign ins_ready  = rdy_en && (count != 3'd4);
  assign push_acc   = ins_valid && ins_ready;
  assign push_store = push_acc && (ins_data[19:16] != RSVD_REG);

  assign head    = fifo_mem[rd_ptr];
  assign head_a1 = head[11:8];
  assign head_a2 = head[15:12];
  assign issue   = (count != 3'd0) && !hazard;
  assign busy    = (count != 3'd0) || sb_busy;

`ifdef ALU_ISSUE_HAZARD_EN
  logic [2:0] sb_v;
  logic [3:0] sb_rd [2];

  // Only entries that survive this cycle's shift can conflict; the oldest retires now,
  // which puts a dependent instruction exactly 3 cycles behind its producer.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (sb_v[i] && ((sb_rd[i] == head_a1) || (sb_rd[i] == head_a2))) hazard = 1'b1;
    end
  end

  assign sb_busy = |sb_v;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb_v     <= 3'b000;
      sb_rd[0] <= 4'h0;
      sb_rd[1] <= 4'h0;
    end else begin
      sb_v     <= {sb_v[1:0], issue};
      sb_rd[1] <= sb_rd[0];
      sb_rd[0] <= issue ? head[19:16] : 4'h0;
    end
  end
`else
  assign hazard  = 1'b0;
  assign sb_busy = 1'b0;
`endif

  always_comb begin
    count_nxt = count;
    case ({push_store, issue})
      2'b10:   count_nxt = count + 3'd1;
      2'b01:   count_nxt = count - 3'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (push_store) fifo_mem[wr_ptr] <= ins_data;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      rdy_en   <= 1'b0;
      err_rsvd <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      count  <= count_nxt;
      if (push_store) wr_ptr <= wr_ptr + 2'd1;
      if (issue)      rd_ptr <= rd_ptr + 2'd1;
      if (push_acc && !push_store) err_rsvd <= 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      write     <= 1'b0;
      func      <= BUBBLE_FUNC;
      rd        <= RSVD_REG;
      addr2     <= RSVD_REG;
      addr1     <= RSVD_REG;
      memaddr   <= 8'h00;
    end else if (issue) begin
      cmd_valid <= 1'b1;
      write     <= head[23];
      func      <= head[22:20];
      rd        <= head[19:16];
      addr2     <= head[15:12];
      addr1     <= head[11:8];
      memaddr   <= head[7:0];
    end else begin
      cmd_valid <= 1'b0;
      write     <= 1'b0;
      func      <= BUBBLE_FUNC;
      rd        <= RSVD_REG;
      addr2     <= RSVD_REG;
      addr1     <= RSVD_REG;
      memaddr   <= 8'h00;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: queue-based scoreboard with a negedge monitor.
// Builds with or without ALU_ISSUE_HAZARD_EN; stall timing expectations follow the macro.
module tb_alu_issue_ctrl;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [23:0] ins_data = 24'h0;
  logic [3:0]  addr1, addr2, rd;
  logic [2:0]  func;
  logic [7:0]  memaddr;
  logic        write, cmd_valid, busy, err_rsvd;

  // Expected issue word: {required gap in cycles since previous issue (0 = any), 24-bit command}
  logic [27:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_cyc = 0;

  alu_issue_ctrl dut (
    .clk1(clk1), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .addr1(addr1), .addr2(addr2), .rd(rd), .func(func),
    .memaddr(memaddr), .write(write), .cmd_valid(cmd_valid), .busy(busy),
    .err_rsvd(err_rsvd)
  );

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  function automatic logic [23:0] mk(input logic w, input logic [2:0] f, input logic [3:0] d,
                                     input logic [3:0] a2, input logic [3:0] a1, input logic [7:0] m);
    return {w, f, d, a2, a1, m};
  endfunction

  // Monitor: every issued command is popped and compared; every other cycle must be a bubble.
  always @(negedge clk1) begin
    logic [23:0] got;
    logic [27:0] e;
    got = {write, func, rd, addr2, addr1, memaddr};
    n_cmp++;
    if (cmd_valid) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue got=%h required=none (cycle %0d)", got, cyc);
      end else begin
        e = exp_q.pop_front();
        if (got !== e[23:0]) begin
          n_fail++;
          $display("FAIL issue_word got=%h required=%h (cycle %0d)", got, e[23:0], cyc);
        end
        if (e[27:24] != 4'd0) begin
          n_cmp++;
          if (cyc - last_cyc != int'(e[27:24])) begin
            n_fail++;
            $display("FAIL issue_gap got=%0d required=%0d (cycle %0d)", cyc - last_cyc, e[27:24], cyc);
          end
        end
      end
      last_cyc = cyc;
    end else if (got !== {1'b0, 3'b010, 4'hF, 4'hF, 4'hF, 8'h00}) begin
      n_fail++;
      $display("FAIL bubble_word got=%h required=%h (cycle %0d)", got, {1'b0, 3'b010, 12'hFFF, 8'h00}, cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic push(input logic [23:0] d, input logic [3:0] gap, input bit expect_issue,
                      output int waits);
    waits = 0;
    ins_valid = 1'b1;
    ins_data  = d;
    while (!ins_ready && waits < 40) begin
      @(posedge clk1); #1;
      waits++;
    end
    if (!ins_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout got=ready0 required=ready1 data=%h", d);
    end else if (expect_issue && d[19:16] != 4'hF) begin
      exp_q.push_back({gap, d});
    end
    @(posedge clk1); #1;
    ins_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(posedge clk1); #1;
      n++;
    end
    n_cmp++;
    if (busy || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got busy=%0b pending=%0d required busy=0 pending=0", busy, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk1);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_rd", rd, 4'hF);
      check("rst_func", func, 3'b010);
      check("rst_ins_ready", ins_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_err_rsvd", err_rsvd, 0);
    end
    rst_n = 1'b1;
    #1 check("release_ready_before_edge", ins_ready, 0);
    @(posedge clk1); #1;
    check("release_ready_after_edge", ins_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    int w;
`ifdef ALU_ISSUE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif
    do_reset();

    // Independent stream: rd=1..4 all reading r0 issue back-to-back in order.
    for (int i = 1; i <= 4; i++)
      push(mk(1'b0, 3'(i), 4'(i), 4'h0, 4'h0, 8'(8'h10 + i)), (i == 1) ? 4'd0 : 4'd1, 1'b1, w);
    drain();

    // RAW: ADD r1<-r2+r3 then SUB r4<-r1-r5.
    push(mk(1'b0, 3'b000, 4'h1, 4'h3, 4'h2, 8'h20), 4'd0, 1'b1, w);
    push(mk(1'b1, 3'b001, 4'h4, 4'h5, 4'h1, 8'h21), HZ ? 4'd3 : 4'd1, 1'b1, w);
    drain();

    // Full FIFO: a dependency chain holds the head; 6th push fills the queue.
    if (HZ) begin
      for (int k = 0; k < 7; k++) begin
        push(mk(1'b0, 3'b100, 4'(k + 1), 4'(k), 4'(k), 8'(8'h30 + k)), (k == 0) ? 4'd0 : 4'd3, 1'b1, w);
        if (k == 5) begin
          check("full_push6_waits", w, 0);
          check("full_ready_low", ins_ready, 0);
          check("full_busy", busy, 1);
        end
        if (k == 6) check("full_push7_waits", w, 2);
      end
    end else begin
      for (int k = 0; k < 5; k++) begin
        push(mk(1'b0, 3'b100, 4'(k + 1), 4'(k), 4'(k), 8'(8'h30 + k)), (k == 0) ? 4'd0 : 4'd1, 1'b1, w);
        check("stream_push_waits", w, 0);
      end
    end
    drain();

    // Reserved destination: dropped, sticky error, queue keeps working.
    check("err_before", err_rsvd, 0);
    push(mk(1'b1, 3'b111, 4'hF, 4'h1, 4'h2, 8'hEE), 4'd0, 1'b1, w);
    check("err_set", err_rsvd, 1);
    check("rsvd_not_queued", busy, 0);
    push(mk(1'b0, 3'b011, 4'h6, 4'h0, 4'h0, 8'h40), 4'd0, 1'b1, w);
    drain();
    check("err_sticky", err_rsvd, 1);

    // Mid-operation reset: only the first of the pushed instructions gets to issue.
    for (int k = 0; k < (HZ ? 4 : 3); k++)
      push(mk(1'b0, 3'b101, 4'(k + 1), 4'(k), 4'(k), 8'(8'h50 + k)), 4'd0, k == 0, w);
    if (HZ) check("midop_busy_before", busy, 1);
    do_reset();
    repeat (6) @(negedge clk1);
    check("midop_busy_after", busy, 0);
    check("midop_pending", exp_q.size(), 0);
    push(mk(1'b0, 3'b110, 4'h7, 4'h0, 4'h0, 8'h60), 4'd0, 1'b1, w);
    drain();

    @(negedge clk1);
    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
